// File: rtl/ula_muldiv.sv
// ula_muldiv: RV32I/RV32M execute unit with valid/ready handshakes on both sides.
// Base ops complete in one cycle; multiply and divide iterate one bit per cycle.
module ula_muldiv #(
  parameter int unsigned XLEN     = 32,
  parameter bit          DIV_FAST = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy
);

  localparam int unsigned     SHW      = $clog2(XLEN);
  localparam int unsigned     CW       = $clog2(XLEN + 1);
  localparam logic [CW-1:0]   CNT_INIT = CW'(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [2:0]          f3_q;
  logic                neg_q;
  logic                dz_q;
  logic [XLEN-1:0]     opnd_q;   // multiplicand (MUL) or divisor (DIV)
  logic [2*XLEN-1:0]   acc_q;    // product accumulator, or {remainder, quotient}

  logic                accept;
  logic [2:0]          f3;
  logic [SHW-1:0]      shamt;
  logic                sign_a, sign_b, a_neg, b_neg;
  logic [XLEN-1:0]     mag_a, mag_b;
  logic                div_zero, div_ovf, fast_op;
  logic [XLEN-1:0]     base_res, fast_res;

  logic [XLEN-1:0]     addend;
  logic [XLEN:0]       mul_sum, div_shift, div_diff;
  logic                div_ok;
  logic [2*XLEN-1:0]   mul_next, div_next, prod_fix;
  logic [XLEN-1:0]     quo, rem, fin_res;

  assign in_ready = !flush && (state == IDLE || (state == DONE && out_ready));
  assign accept   = in_valid && in_ready;
  assign busy     = (state == MUL) || (state == DIV);
  assign f3       = op[2:0];
  assign shamt    = b[SHW-1:0];

  always_comb begin
    case (op[3:0])
      4'd1:    base_res = a - b;
      4'd2:    base_res = a ^ b;
      4'd3:    base_res = a | b;
      4'd4:    base_res = a & b;
      4'd5:    base_res = a << shamt;
      4'd6:    base_res = a >> shamt;
      4'd7:    base_res = $unsigned($signed(a) >>> shamt);
      4'd8:    base_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      4'd9:    base_res = {{(XLEN-1){1'b0}}, a < b};
      default: base_res = a + b;
    endcase
  end

  always_comb begin
    if (f3[2]) begin
      sign_a = !f3[0];
      sign_b = !f3[0];
    end else begin
      sign_a = (f3 == 3'b001) || (f3 == 3'b010);
      sign_b = (f3 == 3'b001);
    end
    a_neg    = sign_a && a[XLEN-1];
    b_neg    = sign_b && b[XLEN-1];
    mag_a    = a_neg ? -a : a;
    mag_b    = b_neg ? -b : b;
    div_zero = (b == '0);
    div_ovf  = !f3[0] && (a == MOST_NEG) && (b == '1);
    fast_op  = !op[4] || (DIV_FAST && f3[2] && (div_zero || div_ovf));
    if (!op[4])        fast_res = base_res;
    else if (div_zero) fast_res = f3[1] ? a : '1;
    else               fast_res = f3[1] ? '0 : a;
  end

  // One shift-add multiplier step and one restoring-divide step share acc_q.
  always_comb begin
    addend    = acc_q[0] ? opnd_q : '0;
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, addend};
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    div_shift = acc_q[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ok    = !div_diff[XLEN];
    div_next  = {div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0], acc_q[XLEN-2:0], div_ok};
    prod_fix  = neg_q ? -mul_next : mul_next;
    quo       = div_next[XLEN-1:0];
    rem       = div_next[2*XLEN-1:XLEN];
    if (state == MUL)  fin_res = (f3_q == 3'b000) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    else if (f3_q[1])  fin_res = neg_q ? -rem : rem;
    else if (dz_q)     fin_res = '1;
    else               fin_res = neg_q ? -quo : quo;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      f3_q      <= '0;
      neg_q     <= 1'b0;
      dz_q      <= 1'b0;
      opnd_q    <= '0;
      acc_q     <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      cnt       <= '0;
    end else if (accept) begin
      f3_q  <= f3;
      neg_q <= (f3[2] && f3[1]) ? a_neg : (a_neg ^ b_neg);
      dz_q  <= div_zero;
      if (fast_op) begin
        state     <= DONE;
        out_valid <= 1'b1;
        result    <= fast_res;
        zero      <= (fast_res == '0);
      end else begin
        state     <= f3[2] ? DIV : MUL;
        out_valid <= 1'b0;
        cnt       <= CNT_INIT;
        opnd_q    <= f3[2] ? mag_b : mag_a;
        acc_q     <= {{XLEN{1'b0}}, f3[2] ? mag_a : mag_b};
      end
    end else begin
      case (state)
        MUL, DIV: begin
          acc_q <= (state == MUL) ? mul_next : div_next;
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            result    <= fin_res;
            zero      <= (fin_res == '0);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_muldiv.sv
// Scoreboard bench for ula_muldiv: directed corner cases plus randomized traffic
// checked against an arithmetic reference model.
module tb_ula_muldiv;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, zero, busy;
  logic [4:0]  op;
  logic [31:0] a, b, result;

  typedef struct {
    logic [31:0] res;
    int          acc_cyc;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  ula_muldiv #(.XLEN(32), .DIV_FAST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sp;
    logic [63:0] up;
    if (!o[4]) begin
      case (o[3:0])
        4'd1:    return x - y;
        4'd2:    return x ^ y;
        4'd3:    return x | y;
        4'd4:    return x & y;
        4'd5:    return x << y[4:0];
        4'd6:    return x >> y[4:0];
        4'd7:    return $unsigned($signed(x) >>> y[4:0]);
        4'd8:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
        4'd9:    return (x < y) ? 32'd1 : 32'd0;
        default: return x + y;
      endcase
    end
    case (o[2:0])
      3'd0: begin up = {32'b0, x} * {32'b0, y}; return up[31:0]; end
      3'd1: begin sp = longint'($signed(x)) * longint'($signed(y)); return sp[63:32]; end
      3'd2: begin sp = longint'($signed(x)) * longint'({32'b0, y}); return sp[63:32]; end
      3'd3: begin up = {32'b0, x} * {32'b0, y}; return up[63:32]; end
      3'd4: begin
        if (y == 32'd0) return 32'hFFFFFFFF;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return x;
        return $unsigned($signed(x) / $signed(y));
      end
      3'd5: return (y == 32'd0) ? 32'hFFFFFFFF : x / y;
      3'd6: begin
        if (y == 32'd0) return x;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'd0;
        return $unsigned($signed(x) % $signed(y));
      end
      default: return (y == 32'd0) ? x : x % y;
    endcase
  endfunction

  function automatic int exp_lat(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    if (!o[4]) return 1;
    if (o[2] && (y == 32'd0 || (!o[0] && x == 32'h80000000 && y == 32'hFFFFFFFF))) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFFFFFF;
      3:       return 32'h80000000;
      4:       return 32'h7FFFFFFF;
      5:       return $urandom_range(0, 40);
      default: return $urandom;
    endcase
  endfunction

  task automatic drive_cycle(input bit v, input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                             input bit ordy, input bit fl, output bit acc);
    @(negedge clk);
    in_valid  = v;
    op        = o;
    a         = x;
    b         = y;
    out_ready = ordy;
    flush     = fl;
    #3;
    acc = v && in_ready;
    if (acc) exp_q.push_back('{res: ref_model(o, x, y), acc_cyc: cyc, lat: exp_lat(o, x, y)});
  endtask

  task automatic idle(input int n, input bit ordy);
    bit acc;
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 5'd0, $urandom, $urandom, ordy, 1'b0, acc);
  endtask

  task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y, input bit ordy);
    bit acc;
    int n = 0;
    do begin
      drive_cycle(1'b1, o, x, y, ordy, 1'b0, acc);
      n++;
    end while (!acc && n < 100);
    check("issue_accept", acc, 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      idle(1, 1'b1);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  // Monitor: pops an expectation on every output handshake.
  bit have_first = 1'b0;
  int first_cyc  = 0;
  always begin
    @(negedge clk);
    #4;
    if (!rst_n || flush) begin
      exp_q.delete();
      have_first = 1'b0;
    end else if (out_valid) begin
      if (!have_first) begin
        have_first = 1'b1;
        first_cyc  = cyc;
      end
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("result", result, e.res);
          check("zero", zero, e.res == 32'd0);
          check("latency", first_cyc - e.acc_cyc, e.lat);
        end
        have_first = 1'b0;
      end
    end else begin
      have_first = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_result", result, 0);
    check("rst_zero", zero, 1);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(5'd1,       32'd5,        32'd5,        1'b1);
    issue(5'd7,       32'h80000000, 32'h21,       1'b1);
    issue(5'b10000,   32'hFFFFFFFF, 32'd2,        1'b1);
    issue(5'b10011,   32'hFFFFFFFF, 32'd2,        1'b1);
    issue(5'b10001,   32'hFFFFFFFF, 32'd2,        1'b1);
    issue(5'b10100,   32'hFFFFFFF9, 32'd2,        1'b1);
    issue(5'b10110,   32'hFFFFFFF9, 32'd2,        1'b1);
    issue(5'b10101,   32'd7,        32'd0,        1'b1);
    issue(5'b10100,   32'h80000000, 32'hFFFFFFFF, 1'b1);
    issue(5'b10110,   32'h80000000, 32'hFFFFFFFF, 1'b1);
    issue(5'b10010,   32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1);
    drain();

    // Backpressure: MUL result held with out_ready low, then back-to-back ADD.
    issue(5'b10000, 32'hFFFFFFFF, 32'd2, 1'b0);
    for (int i = 0; i < 40 && !out_valid; i++) idle(1, 1'b0);
    check("bp_valid", out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      idle(1, 1'b0);
      check("bp_result", result, 32'hFFFFFFFE);
      check("bp_in_ready", in_ready, 0);
    end
    drive_cycle(1'b1, 5'd0, 32'd3, 32'd4, 1'b1, 1'b0, acc);
    check("bp_add_accept", acc, 1);
    drain();

    // Asynchronous reset in the middle of a divide.
    issue(5'b10101, 32'd1000, 32'd7, 1'b1);
    idle(5, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_result", result, 0);
    check("midrst_zero", zero, 1);
    check("midrst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Flush mid-divide with a competing in_valid.
    issue(5'b10100, 32'd1000, 32'd3, 1'b1);
    idle(11, 1'b1);
    check("flush_busy_before", busy, 1);
    drive_cycle(1'b1, 5'd0, 32'd1, 32'd1, 1'b1, 1'b1, acc);
    check("flush_not_accepted", acc, 0);
    idle(1, 1'b1);
    check("flush_in_ready", in_ready, 1);
    check("flush_out_valid", out_valid, 0);
    check("flush_busy_after", busy, 0);
    idle(40, 1'b1);
    drain();

    for (int i = 0; i < 3000; i++) begin
      logic [4:0] o;
      o = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 15)) : {1'b1, 1'($urandom), 3'($urandom)};
      drive_cycle($urandom_range(0, 9) < 8, o, rand_val(), rand_val(),
                  $urandom_range(0, 9) < 7, $urandom_range(0, 99) < 2, acc);
    end
    flush = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
